// File: rtl/imem_loader.sv
// Host-side loader for the instruction memory: streams words in from address 0,
// then gates the PC with start for the program length plus a drain window.
module imem_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DRAIN  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_load,
    input  logic              cmd_run,
    input  logic              cmd_halt,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              start,
    output logic [ADDR_W:0]   loaded_count,
    output logic [1:0]        state_out,
    output logic              err_overflow
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int RW = ADDR_W + 5;

    state_t        state_reg;
    logic [RW-1:0] run_cnt_reg;
    logic [RW-1:0] run_last;
    logic          full;
    logic          handshake;

    // loaded_count doubles as the write pointer; its top bit means the memory is full.
    assign full      = loaded_count[ADDR_W];
    assign wr_ready  = (state_reg == LOAD) && !full;
    assign handshake = wr_valid && wr_ready;
    assign state_out = state_reg;
    assign run_last  = RW'(loaded_count) + RW'(DRAIN) - RW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            run_cnt_reg  <= '0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            start        <= 1'b0;
            loaded_count <= '0;
            err_overflow <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (handshake) begin
                imem_we      <= 1'b1;
                imem_waddr   <= loaded_count[ADDR_W-1:0];
                imem_wdata   <= wr_data;
                loaded_count <= loaded_count + 1'b1;
            end
            if ((state_reg == LOAD) && full && wr_valid) begin
                err_overflow <= 1'b1;
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (cmd_halt) begin
                        state_reg <= state_reg;
                    end else if (cmd_load) begin
                        state_reg    <= LOAD;
                        loaded_count <= '0;
                        err_overflow <= 1'b0;
                    end else if (cmd_run && (loaded_count != '0)) begin
                        state_reg   <= RUN;
                        run_cnt_reg <= '0;
                    end
                end
                LOAD: begin
                    // cmd_load outranks cmd_run, so it keeps the load open.
                    if (cmd_halt) begin
                        state_reg <= IDLE;
                    end else if (!cmd_load && cmd_run) begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    // The entry cycle has start low; start is then high for
                    // loaded_count-1+DRAIN cycles while run_cnt steps 1..run_last.
                    if (cmd_halt || (run_cnt_reg == run_last)) begin
                        start     <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        start       <= 1'b1;
                        run_cnt_reg <= run_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a vector table for reset/load/handshake,
// plus hand sequences for run windows, halt, overflow and mid-operation reset.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_load, cmd_run, cmd_halt, wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready, imem_we, start, err_overflow;
    logic [8:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [9:0]  loaded_count;
    logic [1:0]  state_out;

    int n_checks = 0;
    int n_pass   = 0;

    imem_loader #(.ADDR_W(9), .DATA_W(32), .DRAIN(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_halt(cmd_halt),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .start(start), .loaded_count(loaded_count), .state_out(state_out),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // rdy is wr_ready seen before the edge; the rest are register values after it.
    typedef struct {
        logic        ld, run, hlt, vld;
        logic [31:0] data;
        logic        rdy, we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic        st;
        logic [1:0]  state;
        logic [9:0]  cnt;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic l, input logic r, input logic h, input logic v,
                         input logic [31:0] d);
        @(negedge clk);
        cmd_load = l; cmd_run = r; cmd_halt = h; wr_valid = v; wr_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic l, input logic r, input logic h, input logic v,
                        input logic [31:0] d);
        drive(l, r, h, v, d);
        tick();
    endtask

    // Clock idle cycles until DONE; returns the number of cycles start was high.
    task automatic run_window(output int highs, output logic reached);
        highs   = 0;
        reached = 1'b0;
        for (int c = 0; c < 40 && !reached; c++) begin
            step(0, 0, 0, 0, 0);
            if (start) highs++;
            if (state_out == 2'd3) reached = 1'b1;
        end
    endtask

    initial begin
        int          highs;
        logic        reached;
        int          bad;
        logic        rose;

        reset = 1'b1;
        cmd_load = 0; cmd_run = 0; cmd_halt = 0; wr_valid = 0; wr_data = 0;
        tick();
        tick();
        chk("rst_start", start, 0);
        chk("rst_ready", wr_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_state", state_out, 0);
        chk("rst_cnt", loaded_count, 0);
        @(negedge clk);
        reset = 1'b0;

        //          ld run hlt vld data    rdy we addr wdata  st state cnt err
        vecs[0] = '{0, 0, 0, 0, 32'h0,  0, 0, 9'd0, 32'h0,  0, 2'd0, 10'd0, 0};
        vecs[1] = '{0, 1, 0, 0, 32'h0,  0, 0, 9'd0, 32'h0,  0, 2'd0, 10'd0, 0};
        vecs[2] = '{1, 0, 0, 0, 32'h0,  0, 0, 9'd0, 32'h0,  0, 2'd1, 10'd0, 0};
        vecs[3] = '{0, 0, 0, 1, 32'hA0, 1, 1, 9'd0, 32'hA0, 0, 2'd1, 10'd1, 0};
        vecs[4] = '{0, 0, 0, 1, 32'hA1, 1, 1, 9'd1, 32'hA1, 0, 2'd1, 10'd2, 0};
        vecs[5] = '{0, 0, 0, 1, 32'hA2, 1, 1, 9'd2, 32'hA2, 0, 2'd1, 10'd3, 0};
        vecs[6] = '{0, 0, 1, 1, 32'hA3, 1, 1, 9'd3, 32'hA3, 0, 2'd0, 10'd4, 0};
        vecs[7] = '{0, 0, 0, 0, 32'h0,  0, 0, 9'd0, 32'h0,  0, 2'd0, 10'd4, 0};
        vecs[8] = '{0, 1, 0, 0, 32'h0,  0, 0, 9'd0, 32'h0,  0, 2'd2, 10'd4, 0};

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].ld, vecs[i].run, vecs[i].hlt, vecs[i].vld, vecs[i].data);
            #1;
            chk($sformatf("v%0d_ready", i), wr_ready, vecs[i].rdy);
            tick();
            chk($sformatf("v%0d_we", i), imem_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("v%0d_addr", i), imem_waddr, vecs[i].addr);
                chk($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].wdata);
            end
            chk($sformatf("v%0d_start", i), start, vecs[i].st);
            chk($sformatf("v%0d_state", i), state_out, vecs[i].state);
            chk($sformatf("v%0d_cnt", i), loaded_count, vecs[i].cnt);
            chk($sformatf("v%0d_err", i), err_overflow, vecs[i].err);
        end

        // 4 words, DRAIN=8: start high for 11 cycles, then DONE.
        run_window(highs, reached);
        chk("run1_done", reached, 1);
        chk("run1_len", highs, 11);
        chk("run1_start_low", start, 0);
        step(0, 1, 0, 0, 0);
        run_window(highs, reached);
        chk("run2_done", reached, 1);
        chk("run2_len", highs, 11);
        chk("run2_cnt", loaded_count, 4);

        // Halt three cycles into the start window.
        step(0, 1, 0, 0, 0);
        rose = 1'b0;
        for (int c = 0; c < 5 && !rose; c++) begin
            step(0, 0, 0, 0, 0);
            rose = start;
        end
        chk("halt_rose", rose, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("halt_pre_start", start, 1);
        step(0, 0, 1, 0, 0);
        chk("halt_start", start, 0);
        chk("halt_state", state_out, 3);
        step(0, 1, 0, 0, 0);
        run_window(highs, reached);
        chk("rerun_len", highs, 11);

        // Fill all 512 entries, then one extra valid word.
        step(1, 0, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            step(0, 0, 0, 1, 32'h1000 + i);
            if (!imem_we || imem_waddr != 9'(i) || imem_wdata != 32'h1000 + i) bad++;
        end
        chk("fill_writes_bad", bad, 0);
        chk("fill_cnt", loaded_count, 512);
        drive(0, 0, 0, 1, 32'hDEAD);
        #1;
        chk("ovf_ready", wr_ready, 0);
        tick();
        chk("ovf_we", imem_we, 0);
        chk("ovf_err", err_overflow, 1);
        chk("ovf_addr_held", imem_waddr, 511);
        chk("ovf_cnt", loaded_count, 512);
        step(0, 0, 0, 0, 0);
        chk("ovf_err_sticky", err_overflow, 1);
        chk("ovf_no_wrap_we", imem_we, 0);

        // Reset mid-load with a word offered on the reset edge.
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hB0);
        step(0, 0, 0, 1, 32'hB1);
        chk("ml_we_before", imem_we, 1);
        drive(0, 0, 0, 1, 32'hB2);
        reset = 1'b1;
        tick();
        chk("ml_we", imem_we, 0);
        chk("ml_state", state_out, 0);
        chk("ml_cnt", loaded_count, 0);
        chk("ml_err", err_overflow, 0);
        chk("ml_addr", imem_waddr, 0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 1, 32'hB3);
        chk("ml_no_write", imem_we, 0);
        step(0, 1, 0, 0, 0);
        chk("ml_run_ignored", state_out, 0);

        // Reset mid-run.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'hC0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("mr_start_before", start, 1);
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk("mr_start", start, 0);
        chk("mr_state", state_out, 0);
        chk("mr_cnt", loaded_count, 0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 0, 0, 0);
        chk("mr_run_ignored", state_out, 0);
        chk("mr_start_after", start, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
